// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the PIPE rate / receiver-detect controller.
// Used by pipe_rate_ctrl and its phystatus collector.
package pipe_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      EIDLE,
      RATE,
      WAIT_PHY,
      DETECT,
      DONE
   } state_t;

   typedef enum logic {
      RATE_CHG = 1'b0,
      RX_DET   = 1'b1
   } op_t;

   typedef enum logic [1:0] {
      OK      = 2'd0,
      TIMEOUT = 2'd1,
      INVALID = 2'd2
   } status_t;

   localparam logic [1:0] GEN1 = 2'd0;
   localparam logic [1:0] GEN2 = 2'd1;
   localparam logic [1:0] GEN3 = 2'd2;
   localparam logic [1:0] GEN4 = 2'd3;

   localparam logic [2:0] RXSTATUS_DETECTED = 3'b011;

endpackage

// File: rtl/pipe_phystatus_collect.sv
// Sticky per-lane phystatus collector; all_seen includes pulses arriving this cycle,
// so the controller can complete on the same edge the last lane reports.
module pipe_phystatus_collect #(
   parameter int NUM_LANES = 16
) (
   input  logic                 pclk,
   input  logic                 reset,
   input  logic                 clear,
   input  logic [NUM_LANES-1:0] mask,
   input  logic [NUM_LANES-1:0] phystatus,
   output logic                 all_seen
);

   logic [NUM_LANES-1:0] seen;
   logic [NUM_LANES-1:0] seen_nxt;

   assign seen_nxt = seen | (phystatus & mask);
   assign all_seen = (seen_nxt == mask);

   always_ff @(posedge pclk) begin
      if (reset || clear) begin
         seen <= '0;
      end else begin
         seen <= seen_nxt;
      end
   end

endmodule

// File: rtl/pipe_rate_ctrl.sv
// PIPE rate-change / receiver-detect sequencer; one command at a time, req_ready only in IDLE.
// Optional handshake timeout enabled by defining PIPE_RATE_CTRL_TIMEOUT_EN.
module pipe_rate_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int NUM_LANES      = 16,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                   pclk,
   input  logic                   reset,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic                   req_op,
   input  logic [1:0]             req_rate,
   input  logic [NUM_LANES-1:0]   lane_mask,
   output logic [1:0]             pipe_rate,
   output logic [NUM_LANES-1:0]   txelecidle,
   output logic [NUM_LANES-1:0]   txdetectrx,
   input  logic [NUM_LANES-1:0]   phystatus,
   input  logic [3*NUM_LANES-1:0] rxstatus,
   output logic                   done,
   output logic [1:0]             done_status,
   output logic [NUM_LANES-1:0]   rx_detected
);

   state_t               state, state_nxt;
   status_t              status_nxt;
   logic [NUM_LANES-1:0] lat_mask;
   logic [1:0]           lat_rate;
   logic [1:0]           saved_rate;
   logic [NUM_LANES-1:0] hit;
   logic                 all_seen;
   logic                 waiting;
   logic                 timeout_hit;

   assign waiting = (state == WAIT_PHY) || (state == DETECT);
   assign hit     = phystatus & lat_mask;

   pipe_phystatus_collect #(.NUM_LANES(NUM_LANES)) u_collect (
      .pclk      (pclk),
      .reset     (reset),
      .clear     (!waiting),
      .mask      (lat_mask),
      .phystatus (phystatus),
      .all_seen  (all_seen)
   );

`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
   logic [15:0] timer;

   always_ff @(posedge pclk) begin
      if (reset || !waiting) begin
         timer <= '0;
      end else begin
         timer <= timer + 16'd1;
      end
   end

   assign timeout_hit = waiting && (timer == 16'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge pclk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      status_nxt = status_t'(done_status);
      req_ready  = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (lane_mask == '0) begin
                  state_nxt  = DONE;
                  status_nxt = INVALID;
               end else if (op_t'(req_op) == RX_DET) begin
                  state_nxt = DETECT;
               end else if (req_rate == pipe_rate) begin
                  state_nxt  = DONE;
                  status_nxt = OK;
               end else begin
                  state_nxt = EIDLE;
               end
            end
         end
         EIDLE: state_nxt = RATE;
         RATE:  state_nxt = WAIT_PHY;
         WAIT_PHY, DETECT: begin
            // Completion wins over a timeout landing on the same edge.
            if (all_seen) begin
               state_nxt  = DONE;
               status_nxt = OK;
            end else if (timeout_hit) begin
               state_nxt  = DONE;
               status_nxt = TIMEOUT;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge pclk) begin
      if (reset) begin
         pipe_rate   <= GEN1;
         txelecidle  <= '1;
         txdetectrx  <= '0;
         rx_detected <= '0;
         done_status <= OK;
         lat_mask    <= '0;
         lat_rate    <= GEN1;
         saved_rate  <= GEN1;
      end else begin
         done_status <= status_nxt;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_mask <= lane_mask;
                  lat_rate <= req_rate;
                  if ((lane_mask != '0) && (op_t'(req_op) == RX_DET)) begin
                     txelecidle <= lane_mask;
                     txdetectrx <= lane_mask;
                  end
               end
            end
            EIDLE: txelecidle <= lat_mask;
            RATE: begin
               saved_rate <= pipe_rate;
               pipe_rate  <= lat_rate;
            end
            WAIT_PHY: begin
               if (timeout_hit && !all_seen) begin
                  pipe_rate <= saved_rate;
               end
            end
            DETECT: begin
               for (int i = 0; i < NUM_LANES; i++) begin
                  if (hit[i]) begin
                     rx_detected[i] <= (rxstatus[3*i +: 3] == RXSTATUS_DETECTED);
                     txdetectrx[i]  <= 1'b0;
                  end
               end
               if (timeout_hit && !all_seen) begin
                  txdetectrx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_rate_ctrl.sv
// Bench for pipe_rate_ctrl: directed commands against a timeline model derived from
// the accept edge and the scheduled phystatus pulses.
module tb_pipe_rate_ctrl;

   localparam int N   = 16;
   localparam int TMO = 8;
   localparam int INF = 1 << 30;
`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
   localparam bit T_EN = 1'b1;
`else
   localparam bit T_EN = 1'b0;
`endif

   logic           pclk = 1'b0;
   logic           reset = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_op = 1'b0;
   logic [1:0]     req_rate = 2'd0;
   logic [N-1:0]   lane_mask = '0;
   logic [1:0]     pipe_rate;
   logic [N-1:0]   txelecidle, txdetectrx, rx_detected;
   logic [N-1:0]   phystatus = '0;
   logic [3*N-1:0] rxstatus = '0;
   logic           done;
   logic [1:0]     done_status;

   always #5 pclk = ~pclk;

   pipe_rate_ctrl #(.NUM_LANES(N), .TIMEOUT_CYCLES(TMO)) dut (
      .pclk        (pclk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_rate    (req_rate),
      .lane_mask   (lane_mask),
      .pipe_rate   (pipe_rate),
      .txelecidle  (txelecidle),
      .txdetectrx  (txdetectrx),
      .phystatus   (phystatus),
      .rxstatus    (rxstatus),
      .done        (done),
      .done_status (done_status),
      .rx_detected (rx_detected)
   );

   int cyc = 0;
   always @(posedge pclk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // Current command and the output values in force before it.
   bit           cm_act = 1'b0;
   bit           cm_op;
   logic [1:0]   cm_rate;
   logic [N-1:0] cm_mask;
   int           cm_a;
   int           pulse_off[N];
   logic [2:0]   rxst_v[N];
   logic [1:0]   b_rate, b_st;
   logic [N-1:0] b_eidle, b_detrx, b_rxdet;

   logic [1:0]   h_rate[64];
   logic         h_done[64];
   logic [N-1:0] h_dtx[64];

   typedef struct {
      logic         rdy;
      logic [1:0]   rate;
      logic [N-1:0] eidle;
      logic [N-1:0] detrx;
      logic [N-1:0] rxdet;
      logic         dn;
      logic [1:0]   st;
   } exp_t;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, want, cyc);
      end
   endtask

   function automatic bit is_immediate();
      return (cm_mask == '0) || (!cm_op && (cm_rate == b_rate));
   endfunction

   // Edge on which the last masked lane reports, or INF if one never does.
   function automatic int last_report();
      int first = cm_op ? cm_a + 1 : cm_a + 3;
      int l = 0;
      for (int i = 0; i < N; i++) begin
         if (cm_mask[i]) begin
            if (pulse_off[i] < 0 || cm_a + pulse_off[i] < first) return INF;
            if (cm_a + pulse_off[i] > l) l = cm_a + pulse_off[i];
         end
      end
      return l;
   endfunction

   function automatic int tmo_edge();
      return cm_op ? cm_a + TMO : cm_a + 2 + TMO;
   endfunction

   function automatic bit timed_out();
      return T_EN && !is_immediate() && (last_report() > tmo_edge());
   endfunction

   function automatic int end_edge();
      if (is_immediate()) return cm_a;
      if (timed_out()) return tmo_edge();
      return last_report();
   endfunction

   // Outputs expected just after edge c.
   function automatic exp_t model(input int c);
      exp_t e;
      int   fin;
      int   p;
      e.rdy = 1'b1; e.dn = 1'b0; e.rate = b_rate; e.eidle = b_eidle;
      e.detrx = b_detrx; e.rxdet = b_rxdet; e.st = b_st;
      if (!cm_act) return e;
      fin = end_edge();
      if (c <= fin) e.rdy = 1'b0;
      if (c == fin) e.dn = 1'b1;
      if (c >= fin) e.st = (cm_mask == '0) ? 2'd2 : (timed_out() ? 2'd1 : 2'd0);
      if (is_immediate()) return e;
      if (!cm_op) begin
         if (c >= cm_a + 1) e.eidle = cm_mask;
         if (c >= cm_a + 2) e.rate = cm_rate;
         if (timed_out() && c >= fin) e.rate = b_rate;
      end else if (c >= cm_a) begin
         e.eidle = cm_mask;
         e.detrx = cm_mask;
         for (int i = 0; i < N; i++) begin
            p = cm_a + pulse_off[i];
            if (cm_mask[i] && pulse_off[i] >= 1 && p <= fin && c >= p) begin
               e.detrx[i] = 1'b0;
               e.rxdet[i] = (rxst_v[i] == 3'b011);
            end
         end
         if (timed_out() && c >= fin) e.detrx = '0;
      end
      return e;
   endfunction

   function automatic exp_t rst_exp();
      exp_t e;
      e.rdy = 1'b1; e.dn = 1'b0; e.rate = 2'd0; e.eidle = '1;
      e.detrx = '0; e.rxdet = '0; e.st = 2'd0;
      return e;
   endfunction

   always @(posedge pclk) begin : cmp
      exp_t e;
      #1;
      if (chk_on) begin
         e = reset ? rst_exp() : model(cyc);
         chk("req_ready",   32'(req_ready),   32'(e.rdy));
         chk("pipe_rate",   32'(pipe_rate),   32'(e.rate));
         chk("txelecidle",  32'(txelecidle),  32'(e.eidle));
         chk("txdetectrx",  32'(txdetectrx),  32'(e.detrx));
         chk("rx_detected", 32'(rx_detected), 32'(e.rxdet));
         chk("done",        32'(done),        32'(e.dn));
         chk("done_status", 32'(done_status), 32'(e.st));
      end
   end

   task automatic sched_clear();
      for (int i = 0; i < N; i++) begin
         pulse_off[i] = -1;
         rxst_v[i]    = 3'b000;
      end
   endtask

   task automatic drive_phy(input int edge_no);
      bit hitv;
      for (int i = 0; i < N; i++) begin
         hitv = cm_act && pulse_off[i] >= 0 && (cm_a + pulse_off[i] == edge_no);
         phystatus[i] = hitv;
         rxstatus[3*i +: 3] = hitv ? rxst_v[i] : ~rxst_v[i];
      end
   endtask

   task automatic base_reset();
      b_rate = 2'd0; b_eidle = '1; b_detrx = '0; b_rxdet = '0; b_st = 2'd0;
   endtask

   task automatic issue(input bit op, input logic [1:0] rt, input logic [N-1:0] m);
      @(negedge pclk);
      req_valid = 1'b1; req_op = op; req_rate = rt; lane_mask = m;
      cm_op = op; cm_rate = rt; cm_mask = m; cm_a = cyc + 1; cm_act = 1'b1;
      for (int k = 0; k < 64; k++) begin
         h_done[k] = 1'b0; h_rate[k] = 2'd0; h_dtx[k] = '0;
      end
      drive_phy(cm_a);
   endtask

   task automatic finish_cmd(output int a_out, output int e_out);
      exp_t e;
      bit   ok = 1'b0;
      a_out = cm_a;
      e_out = end_edge();
      for (int k = 0; k < 400; k++) begin
         @(negedge pclk);
         req_valid = 1'b0;
         if (cyc - cm_a >= 0 && cyc - cm_a < 64) begin
            h_rate[cyc - cm_a] = pipe_rate;
            h_done[cyc - cm_a] = done;
            h_dtx[cyc - cm_a]  = txdetectrx;
         end
         if (cyc >= e_out + 1) begin
            ok = 1'b1;
            break;
         end
         drive_phy(cyc + 1);
      end
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL cmd_wait: command accepted at edge %0d not finished, got cycle %0d want <= %0d", cm_a, cyc, e_out + 1);
      end
      phystatus = '0;
      e = model(cyc);
      b_rate = e.rate; b_eidle = e.eidle; b_detrx = e.detrx; b_rxdet = e.rxdet; b_st = e.st;
      cm_act = 1'b0;
   endtask

   initial begin
      int a, fin, dn;
      sched_clear();
      base_reset();
      repeat (3) @(negedge pclk);
      chk_on = 1'b1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_eidle", 32'(txelecidle), 32'hFFFF);
      chk("rst_rate", 32'(pipe_rate), 32'd0);
      reset = 1'b0;
      @(negedge pclk);

      // Rate change 0 -> 2, lanes 0..3 report one per cycle.
      sched_clear();
      for (int i = 0; i < 4; i++) pulse_off[i] = 3 + i;
      issue(1'b0, 2'd2, 16'h000F);
      finish_cmd(a, fin);
      chk("t2_latency", 32'(fin - a), 32'd6);
      chk("t2_rate_a1", 32'(h_rate[1]), 32'd0);
      chk("t2_rate_a2", 32'(h_rate[2]), 32'd2);
      chk("t2_done_a5", 32'(h_done[5]), 32'd0);
      chk("t2_done_a6", 32'(h_done[6]), 32'd1);
      chk("t2_status", 32'(done_status), 32'd0);
      chk("t2_eidle", 32'(txelecidle), 32'h000F);

      // Receiver detect on lanes 0,1: lane 0 detected, lane 1 not.
      sched_clear();
      pulse_off[0] = 1; rxst_v[0] = 3'b011;
      pulse_off[1] = 2; rxst_v[1] = 3'b000;
      issue(1'b1, 2'd0, 16'h0003);
      finish_cmd(a, fin);
      chk("t3_latency", 32'(fin - a), 32'd2);
      chk("t3_detrx_a0", 32'(h_dtx[0]), 32'h0003);
      chk("t3_detrx_a1", 32'(h_dtx[1]), 32'h0002);
      chk("t3_rxdet", 32'(rx_detected), 32'h0001);
      chk("t3_detrx", 32'(txdetectrx), 32'h0000);
      chk("t3_status", 32'(done_status), 32'd0);

      // Empty lane mask.
      sched_clear();
      issue(1'b0, 2'd3, 16'h0000);
      finish_cmd(a, fin);
      chk("t4_done_a0", 32'(h_done[0]), 32'd1);
      chk("t4_status", 32'(done_status), 32'd2);
      chk("t4_rate", 32'(pipe_rate), 32'd2);
      chk("t4_eidle", 32'(txelecidle), 32'h0003);

      // Rate change to the current rate.
      issue(1'b0, 2'd2, 16'h00FF);
      finish_cmd(a, fin);
      chk("t5_done_a0", 32'(h_done[0]), 32'd1);
      chk("t5_status", 32'(done_status), 32'd0);
      chk("t5_eidle", 32'(txelecidle), 32'h0003);

      // Unmasked lanes 5 and 7 pulse early; only lane 0 completes.
      sched_clear();
      pulse_off[5] = 3; pulse_off[7] = 5; pulse_off[0] = 8;
      issue(1'b0, 2'd1, 16'h0001);
      finish_cmd(a, fin);
      chk("t6_latency", 32'(fin - a), 32'd8);
      chk("t6_done_a7", 32'(h_done[7]), 32'd0);
      chk("t6_done_a8", 32'(h_done[8]), 32'd1);
      chk("t6_rate", 32'(pipe_rate), 32'd1);

      // Detect on all lanes, reports staggered, odd lanes detected.
      sched_clear();
      for (int i = 0; i < N; i++) begin
         pulse_off[i] = 1 + (i % 4);
         rxst_v[i]    = i[0] ? 3'b011 : 3'b001;
      end
      issue(1'b1, 2'd0, 16'hFFFF);
      finish_cmd(a, fin);
      chk("t7_latency", 32'(fin - a), 32'd4);
      chk("t7_rxdet", 32'(rx_detected), 32'hAAAA);
      chk("t7_eidle", 32'(txelecidle), 32'hFFFF);

`ifdef PIPE_RATE_CTRL_TIMEOUT_EN
      // Rate change 1 -> 3 with no PHY response.
      sched_clear();
      issue(1'b0, 2'd3, 16'h0003);
      finish_cmd(a, fin);
      chk("t9_latency", 32'(fin - a), 32'd10);
      chk("t9_rate_a2", 32'(h_rate[2]), 32'd3);
      chk("t9_done_a10", 32'(h_done[10]), 32'd1);
      chk("t9_status", 32'(done_status), 32'd1);
      chk("t9_rate", 32'(pipe_rate), 32'd1);
`endif

      // Reset while waiting for lane 1.
      sched_clear();
      pulse_off[0] = 3;
      issue(1'b0, 2'd3, 16'h0003);
      for (int k = 0; k < 20; k++) begin
         @(negedge pclk);
         req_valid = 1'b0;
         if (cyc >= cm_a + 4) break;
         drive_phy(cyc + 1);
      end
      chk("t8_wait_ready", 32'(req_ready), 32'd0);
      chk("t8_wait_rate", 32'(pipe_rate), 32'd3);
      reset = 1'b1;
      cm_act = 1'b0;
      phystatus = '0;
      base_reset();
      dn = 0;
      repeat (2) begin
         @(negedge pclk);
         dn += int'(done);
      end
      reset = 1'b0;
      @(negedge pclk);
      dn += int'(done);
      chk("t8_no_done", 32'(dn), 32'd0);
      chk("t8_ready", 32'(req_ready), 32'd1);
      chk("t8_rate", 32'(pipe_rate), 32'd0);
      chk("t8_eidle", 32'(txelecidle), 32'hFFFF);

      // Rate change 0 -> 3, every lane reports on the first wait cycle.
      sched_clear();
      for (int i = 0; i < N; i++) pulse_off[i] = 3;
      issue(1'b0, 2'd3, 16'hFFFF);
      finish_cmd(a, fin);
      chk("t10_latency", 32'(fin - a), 32'd3);
      chk("t10_rate", 32'(pipe_rate), 32'd3);
      chk("t10_status", 32'(done_status), 32'd0);

      @(negedge pclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_rate_ctrl.md
PIPE_RATE_CTRL -- requirements
Module: pipe_rate_ctrl

Interface
REQ-001 SHALL have parameter NUM_LANES, default 16: number of PIPE lanes controlled.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: pclk cycles allowed for a PHY handshake before timeout (range 1..65535).
REQ-003 SHALL have port: pclk  in  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports: req_valid in 1, req_ready out 1  valid/ready command handshake.
REQ-006 SHALL have port: req_op  in  1  0 = rate change, 1 = receiver detect.
REQ-007 SHALL have port: req_rate  in  2  target rate for a rate change (0 = Gen1 .. 3 = Gen4).
REQ-008 SHALL have port: lane_mask  in  NUM_LANES  lanes taking part in the command.
REQ-009 SHALL have port: pipe_rate  out  2  common PIPE rate.
REQ-010 SHALL have ports: txelecidle out NUM_LANES, txdetectrx out NUM_LANES  per-lane PIPE controls.
REQ-011 SHALL have ports: phystatus in NUM_LANES, rxstatus in 3*NUM_LANES  PIPE status; rxstatus lane i is bits [3i+2:3i].
REQ-012 SHALL have ports: done out 1 (one-cycle completion pulse), done_status out 2 (0 = OK, 1 = TIMEOUT, 2 = INVALID), rx_detected out NUM_LANES.

Function
REQ-013 SHALL implement FSM states IDLE, EIDLE, RATE, WAIT_PHY, DETECT, DONE.
REQ-014 SHALL drive req_ready = 1 only in IDLE; a command is accepted on the cycle req_valid && req_ready, and lane_mask, req_op and req_rate are latched on that cycle.
REQ-015 SHALL treat lane_mask == 0 as INVALID: go IDLE -> DONE with done_status = 2 and no change to any PIPE output.
REQ-016 SHALL complete a rate change with req_rate == pipe_rate as IDLE -> DONE with status 0 and no PIPE toggling.
REQ-017 For a rate change, SHALL sequence: EIDLE sets txelecidle for masked lanes (1 cycle) -> RATE drives pipe_rate = req_rate and saves the prior rate (1 cycle) -> WAIT_PHY.
REQ-018 In WAIT_PHY, SHALL keep a sticky per-lane seen mask; a phystatus pulse on a masked lane sets its bit, and a pulse on the same cycle WAIT_PHY is entered counts.
REQ-019 SHALL ignore phystatus on unmasked lanes in all states.
REQ-020 SHALL go WAIT_PHY -> DONE (status 0) on the cycle after seen == latched mask.
REQ-021 For receiver detect, SHALL enter DETECT with txelecidle = 1 and txdetectrx = 1 on masked lanes.
REQ-022 In DETECT, on the cycle a masked lane's phystatus is 1, SHALL set rx_detected[i] = (rxstatus lane i == 3'b011) and deassert txdetectrx[i] on the next cycle.
REQ-023 SHALL go DETECT -> DONE once every masked lane has reported; rx_detected bits of unmasked lanes hold their previous value.
REQ-024 SHALL hold DONE for exactly 1 cycle with done = 1 and a valid done_status, then return to IDLE; done_status holds until the next DONE.
REQ-025 SHALL leave txelecidle unchanged after completion; txelecidle is cleared only by a later command or by reset.

Reset
REQ-026 On reset = 1 at a pclk edge, SHALL set: state IDLE, pipe_rate 0, txelecidle all 1, txdetectrx 0, done 0, done_status 0, rx_detected 0, seen mask 0, timer 0.
REQ-027 Reset mid-command SHALL abort the command, with no done pulse; req_ready = 1 on the first cycle after reset deasserts.

Configuration
REQ-028 With macro PIPE_RATE_CTRL_TIMEOUT_EN defined, SHALL count cycles in WAIT_PHY and DETECT. When the count reaches TIMEOUT_CYCLES, SHALL go to DONE with status 1, deassert txdetectrx, and restore pipe_rate to the saved rate after a rate change.
REQ-029 Without PIPE_RATE_CTRL_TIMEOUT_EN, SHALL contain no timer logic; WAIT_PHY and DETECT wait indefinitely; done_status never equals 1.

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold the FSM state enum, the op enum (RATE_CHG, RX_DET), the status enum (OK, TIMEOUT, INVALID), the Gen1..Gen4 rate encodings and the RXSTATUS_DETECTED = 3'b011 constant.
REQ-031 The sticky per-lane phystatus collector SHALL be sub-module pipe_phystatus_collect, with inputs clear, mask and phystatus and output all_seen.

Verification
REQ-032 Rate change 0 -> 2, mask 16'h000F, phystatus on lanes 0-3 in separate cycles -> pipe_rate = 2 two cycles after accept; done with status 0 one cycle after the last pulse.
REQ-033 Receiver detect, mask 16'h0003: lane0 rxstatus 3'b011, lane1 3'b000 -> rx_detected = 16'h0001; txdetectrx cleared per lane; done with status 0.
REQ-034 lane_mask = 0 -> done one cycle after accept with status 2; PIPE outputs unchanged.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES = 8, rate change 1 -> 3 with no phystatus -> done with status 1; pipe_rate back to 1.
REQ-036 Reset asserted in WAIT_PHY -> no done pulse; pipe_rate 0, txelecidle all 1, req_ready = 1 the cycle after release.
REQ-037 Phystatus on unmasked lane 5 only, mask 16'h0001 -> remain in WAIT_PHY until lane 0 pulses.
